// File: rtl/flit_receiver_pkg.sv
// Shared types and helpers for the flit receiver: FSM state encoding,
// FIFO entry sideband width and saturating counter increments.
package flit_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // FIFO entry carries {err, last} above the payload word
  localparam int ENTRY_META_W = 2;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/flit_receiver_if.sv
// Switch-local-port flit channel plus IP-side payload stream.
// slave = the receiver; master = the switch/IP environment driving it.
interface flit_receiver_if
  import flit_receiver_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4
) ();

  logic [DATA_SIZE+ADDR_SIZE:0] data_i;
  logic                         wr_ready_in;
  logic                         r_ready_out;
  logic [DATA_SIZE-1:0]         pkt_data_o;
  logic                         pkt_last_o;
  logic                         pkt_err_o;
  logic                         pkt_valid_o;
  logic                         pkt_ready_i;

  modport slave (
    input  data_i, wr_ready_in, pkt_ready_i,
    output r_ready_out, pkt_data_o, pkt_last_o, pkt_err_o, pkt_valid_o
  );

  modport master (
    output data_i, wr_ready_in, pkt_ready_i,
    input  r_ready_out, pkt_data_o, pkt_last_o, pkt_err_o, pkt_valid_o
  );

endinterface

// File: rtl/flit_receiver_fifo.sv
// Generic FIFO, depth 2**LOG2; head word visible the cycle after its push.
// Push is refused when full unless the same-cycle pop frees the slot.
module flit_fifo
  import flit_receiver_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LOG2  = 3
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << LOG2;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LOG2-1:0]  wptr_q;
  logic [LOG2-1:0]  rptr_q;
  logic [LOG2:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (LOG2+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + LOG2'(1);
      if (do_pop)  rptr_q <= rptr_q + LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (LOG2+1)'(1);
        2'b01:   cnt_q <= cnt_q - (LOG2+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/flit_receiver.sv
// Node receive NI: checks head address, reassembles packets into the payload FIFO, counts good/bad packets.
// Word visible 1 cycle after push; r_ready_out drops on FIFO full (except DROP); FLIT_RECV_TIMEOUT_EN adds idle abort.
module flit_receiver
  import flit_receiver_pkg::*;
#(
  parameter int DATA_SIZE    = 32,
  parameter int ADDR_SIZE    = 4,
  parameter int ADDR         = 0,
  parameter int MAX_PACK_LEN = 8,
  parameter int MEM_LOG2     = 3,
  parameter int TIMEOUT      = 64
) (
  input  logic          clk,
  input  logic          a_rst,
  flit_receiver_if.slave bus,
  output logic [31:0]   recv_packs,
  output logic [15:0]   err_packs,
  output logic          busy_o
);

  localparam int TAIL_BIT = DATA_SIZE + ADDR_SIZE;
  localparam int ADDR_LSB = DATA_SIZE;
  localparam int ENTRY_W  = DATA_SIZE + ENTRY_META_W;
  localparam logic [ADDR_SIZE-1:0] MY_ADDR  = ADDR[ADDR_SIZE-1:0];
  localparam logic [7:0]           MAX_LEN8 = MAX_PACK_LEN[7:0];

  if (MAX_PACK_LEN < 1 || MAX_PACK_LEN > 255 || TIMEOUT < 1) begin : g_param_chk
    $error("flit_receiver: MAX_PACK_LEN must be 1..255 and TIMEOUT >= 1");
  end

  state_e               state_q, state_d;
  logic [7:0]           len_q, len_d;
  logic                 en_q;
  logic [31:0]          recv_q;
  logic [15:0]          err_q;

  logic                 r_ready;
  logic                 flit_acc;
  logic                 f_tail;
  logic [ADDR_SIZE-1:0] f_addr;
  logic [DATA_SIZE-1:0] f_data;
  logic                 addr_hit;
  logic [7:0]           len_next;
  logic                 at_max;

  logic                 push;
  logic                 push_err;
  logic                 push_last;
  logic [DATA_SIZE-1:0] push_data;
  logic                 inc_recv;
  logic                 inc_err;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_dout;

  assign f_tail   = bus.data_i[TAIL_BIT];
  assign f_addr   = bus.data_i[ADDR_LSB +: ADDR_SIZE];
  assign f_data   = bus.data_i[DATA_SIZE-1:0];
  assign addr_hit = (f_addr == MY_ADDR);
  assign len_next = len_q + 8'd1;
  assign at_max   = (len_next == MAX_LEN8);
  assign flit_acc = bus.wr_ready_in & r_ready;

`ifdef FLIT_RECV_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic            abort_q, abort_d;
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            abort_fire;

  assign abort_fire = abort_q & ~fifo_full;
  // Abort word must not race an incoming flit for the FIFO slot
  assign r_ready    = en_q & ~abort_q & ((state_q == ST_DROP) | ~fifo_full);
`else
  assign r_ready    = en_q & ((state_q == ST_DROP) | ~fifo_full);
`endif

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
`ifdef FLIT_RECV_TIMEOUT_EN
      abort_q    <= 1'b0;
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
`ifdef FLIT_RECV_TIMEOUT_EN
      abort_q    <= abort_d;
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (flit_acc) begin
      case (state_q)
        ST_IDLE: begin
          if (!addr_hit) begin
            state_d = f_tail ? ST_IDLE : ST_DROP;
          end else begin
            len_d = 8'd1;
            if (!f_tail) state_d = (MAX_LEN8 == 8'd1) ? ST_DROP : ST_BODY;
          end
        end
        ST_BODY: begin
          len_d = len_next;
          if (f_tail)      state_d = ST_IDLE;
          else if (at_max) state_d = ST_DROP;
        end
        ST_DROP: begin
          if (f_tail) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
`ifdef FLIT_RECV_TIMEOUT_EN
    abort_d    = abort_q;
    idle_cnt_d = idle_cnt_q;
    if (abort_q) begin
      idle_cnt_d = '0;
      if (!fifo_full) begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
    end else if (flit_acc || state_q == ST_IDLE) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == TO_W'(TIMEOUT)) begin
      idle_cnt_d = '0;
      if (state_q == ST_DROP) state_d = ST_IDLE;
      else                    abort_d = 1'b1;
    end else begin
      idle_cnt_d = idle_cnt_q + TO_W'(1);
    end
`endif
  end

  always_comb begin
    push      = 1'b0;
    push_err  = 1'b0;
    push_last = 1'b0;
    push_data = f_data;
    inc_recv  = 1'b0;
    inc_err   = 1'b0;
    if (flit_acc) begin
      case (state_q)
        ST_IDLE: begin
          if (!addr_hit) begin
            inc_err = 1'b1;
          end else begin
            push      = 1'b1;
            push_last = f_tail;
            if (f_tail) begin
              inc_recv = 1'b1;
            end else if (MAX_LEN8 == 8'd1) begin
              push_last = 1'b1;
              push_err  = 1'b1;
              inc_err   = 1'b1;
            end
          end
        end
        ST_BODY: begin
          push = 1'b1;
          if (f_tail) begin
            push_last = 1'b1;
            inc_recv  = 1'b1;
          end else if (at_max) begin
            push_last = 1'b1;
            push_err  = 1'b1;
            inc_err   = 1'b1;
          end
        end
        default: ;
      endcase
    end
`ifdef FLIT_RECV_TIMEOUT_EN
    if (abort_fire) begin
      push      = 1'b1;
      push_err  = 1'b1;
      push_last = 1'b1;
      push_data = '0;
      inc_err   = 1'b1;
    end
`endif
  end

  // en holds r_ready_out low for the first edge after reset release
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      en_q   <= 1'b0;
      recv_q <= '0;
      err_q  <= '0;
    end else begin
      en_q <= 1'b1;
      if (inc_recv) recv_q <= sat_inc32(recv_q);
      if (inc_err)  err_q  <= sat_inc16(err_q);
    end
  end

  flit_fifo #(
    .WIDTH (ENTRY_W),
    .LOG2  (MEM_LOG2)
  ) u_fifo (
    .clk   (clk),
    .a_rst (a_rst),
    .push  (push),
    .din   ({push_err, push_last, push_data}),
    .pop   (bus.pkt_ready_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.r_ready_out = r_ready;
  assign bus.pkt_valid_o = ~fifo_empty;
  assign bus.pkt_err_o   = fifo_dout[DATA_SIZE+1];
  assign bus.pkt_last_o  = fifo_dout[DATA_SIZE];
  assign bus.pkt_data_o  = fifo_dout[DATA_SIZE-1:0];
  assign recv_packs      = recv_q;
  assign err_packs       = err_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_flit_receiver.sv
// Directed bench for flit_receiver: ADDR=3, MAX_PACK_LEN=4, FIFO depth 4, TIMEOUT=10.
module tb_flit_receiver;

  logic        clk;
  logic        a_rst;
  logic [31:0] recv_packs;
  logic [15:0] err_packs;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  logic [33:0] q[$];

  flit_receiver_if #(.DATA_SIZE(32), .ADDR_SIZE(4)) bus ();

  flit_receiver #(
    .DATA_SIZE    (32),
    .ADDR_SIZE    (4),
    .ADDR         (3),
    .MAX_PACK_LEN (4),
    .MEM_LOG2     (2),
    .TIMEOUT      (10)
  ) dut (
    .clk        (clk),
    .a_rst      (a_rst),
    .bus        (bus),
    .recv_packs (recv_packs),
    .err_packs  (err_packs),
    .busy_o     (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Words leaving the FIFO, captured mid-cycle ahead of the popping edge
  always @(negedge clk) begin
    if (a_rst && bus.pkt_valid_o && bus.pkt_ready_i)
      q.push_back({bus.pkt_err_o, bus.pkt_last_o, bus.pkt_data_o});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input string tag, input logic e, input logic l, input logic [31:0] d);
    logic [33:0] w;
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=no word expected=%0h", tag, {e, l, d});
    end else begin
      w = q.pop_front();
      check(tag, w, {e, l, d});
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic t, input logic [3:0] a, input logic [31:0] d);
    int n;
    n = 0;
    bus.data_i      = {t, a, d};
    bus.wr_ready_in = 1'b1;
    while (!bus.r_ready_out && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("send_rdy", bus.r_ready_out, 1'b1);
    if (bus.r_ready_out) begin
      @(posedge clk);
      #1;
    end
    bus.wr_ready_in = 1'b0;
  endtask

  initial begin
    a_rst           = 1'b0;
    bus.data_i      = '0;
    bus.wr_ready_in = 1'b0;
    bus.pkt_ready_i = 1'b1;
    #12;
    check("rst_rdy",   bus.r_ready_out, 1'b0);
    check("rst_valid", bus.pkt_valid_o, 1'b0);
    check("rst_recv",  recv_packs, 32'd0);
    check("rst_err",   err_packs, 16'd0);
    check("rst_busy",  busy_o, 1'b0);
    @(posedge clk);
    #1;
    a_rst = 1'b1;
    check("rel_rdy_lo", bus.r_ready_out, 1'b0);
    cycles(1);
    check("rel_rdy_hi", bus.r_ready_out, 1'b1);

    // 3-flit good packet
    send(1'b0, 4'd3, 32'hA1);
    check("p1_busy_body", busy_o, 1'b1);
    send(1'b0, 4'd3, 32'hA2);
    send(1'b1, 4'd3, 32'hA3);
    check("p1_busy_idle", busy_o, 1'b0);
    cycles(3);
    expect_word("p1_w1", 1'b0, 1'b0, 32'hA1);
    expect_word("p1_w2", 1'b0, 1'b0, 32'hA2);
    expect_word("p1_w3", 1'b0, 1'b1, 32'hA3);
    check("p1_recv", recv_packs, 32'd1);
    check("p1_err",  err_packs, 16'd0);

    // single-flit packet
    send(1'b1, 4'd3, 32'h55);
    check("p2_busy", busy_o, 1'b0);
    cycles(3);
    expect_word("p2_w1", 1'b0, 1'b1, 32'h55);
    check("p2_recv", recv_packs, 32'd2);

    // misaddressed 2-flit packet, then a good one
    send(1'b0, 4'd5, 32'hB1);
    check("p3_busy_drop", busy_o, 1'b1);
    check("p3_rdy", bus.r_ready_out, 1'b1);
    send(1'b1, 4'd5, 32'hB2);
    check("p3_busy_idle", busy_o, 1'b0);
    cycles(3);
    check("p3_nopush", q.size(), 0);
    check("p3_err", err_packs, 16'd1);
    send(1'b1, 4'd3, 32'hC1);
    cycles(3);
    expect_word("p3_good", 1'b0, 1'b1, 32'hC1);
    check("p3_recv", recv_packs, 32'd3);

    // 6-flit packet truncated at 4
    send(1'b0, 4'd3, 32'hD1);
    send(1'b0, 4'd3, 32'hD2);
    send(1'b0, 4'd3, 32'hD3);
    send(1'b0, 4'd3, 32'hD4);
    check("p4_busy_drop", busy_o, 1'b1);
    send(1'b0, 4'd3, 32'hD5);
    send(1'b1, 4'd3, 32'hD6);
    check("p4_busy_idle", busy_o, 1'b0);
    cycles(3);
    check("p4_count", q.size(), 4);
    expect_word("p4_w1", 1'b0, 1'b0, 32'hD1);
    expect_word("p4_w2", 1'b0, 1'b0, 32'hD2);
    expect_word("p4_w3", 1'b0, 1'b0, 32'hD3);
    expect_word("p4_w4", 1'b1, 1'b1, 32'hD4);
    check("p4_err",  err_packs, 16'd2);
    check("p4_recv", recv_packs, 32'd3);

    // backpressure: 4-flit + 2-flit packets with IP stalled
    bus.pkt_ready_i = 1'b0;
    send(1'b0, 4'd3, 32'hE1);
    send(1'b0, 4'd3, 32'hE2);
    send(1'b0, 4'd3, 32'hE3);
    check("p5_rdy_3", bus.r_ready_out, 1'b1);
    send(1'b1, 4'd3, 32'hE4);
    check("p5_rdy_full", bus.r_ready_out, 1'b0);
    check("p5_valid", bus.pkt_valid_o, 1'b1);
    check("p5_recv4", recv_packs, 32'd4);
    bus.data_i      = {1'b0, 4'd3, 32'hF1};
    bus.wr_ready_in = 1'b1;
    cycles(3);
    check("p5_rdy_stall", bus.r_ready_out, 1'b0);
    check("p5_no_out", q.size(), 0);
    bus.pkt_ready_i = 1'b1;
    send(1'b0, 4'd3, 32'hF1);
    send(1'b1, 4'd3, 32'hF2);
    cycles(6);
    check("p5_count", q.size(), 6);
    expect_word("p5_w1", 1'b0, 1'b0, 32'hE1);
    expect_word("p5_w2", 1'b0, 1'b0, 32'hE2);
    expect_word("p5_w3", 1'b0, 1'b0, 32'hE3);
    expect_word("p5_w4", 1'b0, 1'b1, 32'hE4);
    expect_word("p5_w5", 1'b0, 1'b0, 32'hF1);
    expect_word("p5_w6", 1'b0, 1'b1, 32'hF2);
    check("p5_recv", recv_packs, 32'd5);

    // reset mid-packet with two words buffered
    bus.pkt_ready_i = 1'b0;
    send(1'b0, 4'd3, 32'h61);
    send(1'b0, 4'd3, 32'h62);
    check("p6_valid_pre", bus.pkt_valid_o, 1'b1);
    check("p6_busy_pre", busy_o, 1'b1);
    a_rst = 1'b0;
    #1;
    check("p6_valid", bus.pkt_valid_o, 1'b0);
    check("p6_recv", recv_packs, 32'd0);
    check("p6_err", err_packs, 16'd0);
    check("p6_rdy_rst", bus.r_ready_out, 1'b0);
    check("p6_busy", busy_o, 1'b0);
    @(posedge clk);
    #1;
    a_rst = 1'b1;
    check("p6_rdy_lo", bus.r_ready_out, 1'b0);
    cycles(1);
    check("p6_rdy_hi", bus.r_ready_out, 1'b1);
    bus.pkt_ready_i = 1'b1;
    cycles(3);
    check("p6_flushed", q.size(), 0);
    send(1'b1, 4'd3, 32'h71);
    cycles(3);
    expect_word("p6_after", 1'b0, 1'b1, 32'h71);
    check("p6_recv_after", recv_packs, 32'd1);

`ifdef FLIT_RECV_TIMEOUT_EN
    // head-only packet, then silence until the idle abort
    send(1'b0, 4'd3, 32'h81);
    cycles(9);
    check("p7_early", q.size(), 1);
    check("p7_busy_wait", busy_o, 1'b1);
    for (int i = 0; i < 40 && q.size() < 2; i++) cycles(1);
    expect_word("p7_head", 1'b0, 1'b0, 32'h81);
    expect_word("p7_abort", 1'b1, 1'b1, 32'h0);
    check("p7_err", err_packs, 16'd1);
    check("p7_busy", busy_o, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
